// File: rtl/mux_arb_rr.sv
// mux_arb_rr: N-channel, W-bit arbitrating multiplexer with val/rdy handshakes.
// A round-robin arbiter (or a forced fixed select) picks one requesting channel
// per cycle. The winning message is captured into a one-entry output register.
module mux_arb_rr #(
    parameter  int p_nchannels = 8,
    parameter  int p_nbits     = 32,
    localparam int p_selbits   = $clog2(p_nchannels)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_nchannels-1:0]         in_val,
    output logic [p_nchannels-1:0]         in_rdy,
    input  logic [p_nchannels*p_nbits-1:0] in_msg,
    input  logic                           fixed_en,
    input  logic [p_selbits-1:0]           fixed_sel,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_nbits-1:0]             out_msg,
    output logic [p_selbits-1:0]           out_sel
);

    logic                 acc;
    logic                 has_win;
    logic [p_selbits-1:0] win;
    logic [p_selbits-1:0] ptr;
    logic [p_selbits-1:0] ptr_next;
    int unsigned          rr_idx;

    // Winner selection: fixed select when forced, else first requester from ptr.
    always_comb begin
        has_win = 1'b0;
        win     = '0;
        rr_idx  = 0;
        if (fixed_en) begin
            // Compare against each legal index so an out-of-range select never wins.
            for (int unsigned i = 0; i < p_nchannels; i++) begin
                if (fixed_sel == p_selbits'(i) && in_val[i]) begin
                    has_win = 1'b1;
                    win     = p_selbits'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < p_nchannels; k++) begin
                rr_idx = (int'(ptr) + k) % p_nchannels;
                if (!has_win && in_val[rr_idx]) begin
                    has_win = 1'b1;
                    win     = p_selbits'(rr_idx);
                end
            end
        end
    end

    // Grant: one-hot on the winner whenever the output stage can accept.
    always_comb begin
        acc    = reset && (!out_val || out_rdy);
        in_rdy = '0;
        if (acc && has_win) begin
            in_rdy[win] = 1'b1;
        end
        ptr_next = (int'(win) == p_nchannels - 1) ? '0 : win + 1'b1;
    end

    // Output register and priority pointer update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_sel <= '0;
            ptr     <= '0;
        end else if (acc && has_win) begin
            out_val <= 1'b1;
            out_msg <= in_msg[int'(win)*p_nbits +: p_nbits];
            out_sel <= win;
            if (!fixed_en) begin
                ptr <= ptr_next;
            end
        end else if (out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_rr.sv
// tb_mux_arb_rr: directed tests on N=8/W=32 and N=4/W=4 instances, plus
// randomized scoreboard runs on N=3/W=1 and N=16/W=64 instances.
module tb_mux_arb_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // N=8, W=32 instance
    logic         reset8;
    logic [7:0]   val8, rdy8;
    logic [255:0] msg8;
    logic         fe8, ov8, or8;
    logic [2:0]   fs8, os8;
    logic [31:0]  om8;

    mux_arb_rr #(.p_nchannels(8), .p_nbits(32)) u8 (
        .clk(clk), .reset(reset8), .in_val(val8), .in_rdy(rdy8), .in_msg(msg8),
        .fixed_en(fe8), .fixed_sel(fs8), .out_val(ov8), .out_rdy(or8),
        .out_msg(om8), .out_sel(os8)
    );

    // N=4, W=4 instance
    logic        reset4;
    logic [3:0]  val4, rdy4;
    logic [15:0] msg4;
    logic        fe4, ov4, or4;
    logic [1:0]  fs4, os4;
    logic [3:0]  om4;

    mux_arb_rr #(.p_nchannels(4), .p_nbits(4)) u4 (
        .clk(clk), .reset(reset4), .in_val(val4), .in_rdy(rdy4), .in_msg(msg4),
        .fixed_en(fe4), .fixed_sel(fs4), .out_val(ov4), .out_rdy(or4),
        .out_msg(om4), .out_sel(os4)
    );

    // Shared random stimulus for the N=3 and N=16 instances
    logic        r_reset;
    logic [15:0] r_val;
    logic [63:0] r_msg [16];
    logic        r_fe, r_ordy;
    logic [3:0]  r_fs;
    int          r_which;

    logic [2:0]    rdy3;
    logic [2:0]    m3;
    logic          ov3, om3;
    logic [1:0]    os3;
    logic [15:0]   rdy16;
    logic [1023:0] m16;
    logic          ov16;
    logic [63:0]   om16;
    logic [3:0]    os16;

    always_comb begin
        for (int i = 0; i < 3; i++) m3[i] = r_msg[i][0];
        for (int i = 0; i < 16; i++) m16[i*64 +: 64] = r_msg[i];
    end

    mux_arb_rr #(.p_nchannels(3), .p_nbits(1)) u3 (
        .clk(clk), .reset(r_reset), .in_val(r_val[2:0]), .in_rdy(rdy3), .in_msg(m3),
        .fixed_en(r_fe), .fixed_sel(r_fs[1:0]), .out_val(ov3), .out_rdy(r_ordy),
        .out_msg(om3), .out_sel(os3)
    );

    mux_arb_rr #(.p_nchannels(16), .p_nbits(64)) u16 (
        .clk(clk), .reset(r_reset), .in_val(r_val), .in_rdy(rdy16), .in_msg(m16),
        .fixed_en(r_fe), .fixed_sel(r_fs), .out_val(ov16), .out_rdy(r_ordy),
        .out_msg(om16), .out_sel(os16)
    );

    logic [15:0] g_rdy;
    logic        g_oval;
    logic [63:0] g_omsg;
    logic [3:0]  g_osel;

    always_comb begin
        if (r_which == 3) begin
            g_rdy  = {13'b0, rdy3};
            g_oval = ov3;
            g_omsg = {63'b0, om3};
            g_osel = {2'b0, os3};
        end else begin
            g_rdy  = rdy16;
            g_oval = ov16;
            g_omsg = om16;
            g_osel = os16;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset8 = 1'b0; val8 = '1; or8 = 1'b1; fe8 = 1'b0;
        msg8 = {8{32'h1234_5678}};
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (rdy8 !== 8'h00) $display("FAIL reset_in_rdy: got %h want 00", rdy8); else n_pass++;
            tick();
            n_checks++; if (ov8 !== 1'b0) $display("FAIL reset_out_val: got %b want 0", ov8); else n_pass++;
            n_checks++; if (om8 !== 32'h0) $display("FAIL reset_out_msg: got %h want 0", om8); else n_pass++;
            n_checks++; if (os8 !== 3'd0) $display("FAIL reset_out_sel: got %0d want 0", os8); else n_pass++;
        end
        reset8 = 1'b1; val8 = '0;
        #1;
        n_checks++; if (rdy8 !== 8'h00) $display("FAIL idle_in_rdy: got %h want 00", rdy8); else n_pass++;
        tick();
        n_checks++; if (ov8 !== 1'b0) $display("FAIL idle_out_val: got %b want 0", ov8); else n_pass++;
    endtask

    task automatic test_single();
        val8 = 8'b0010_0000; msg8 = '0; msg8[5*32 +: 32] = 32'hDEADBEEF; or8 = 1'b1;
        #1;
        n_checks++; if (rdy8 !== 8'b0010_0000) $display("FAIL single_grant: got %b want 00100000", rdy8); else n_pass++;
        tick();
        n_checks++; if (ov8 !== 1'b1) $display("FAIL single_val: got %b want 1", ov8); else n_pass++;
        n_checks++; if (om8 !== 32'hDEADBEEF) $display("FAIL single_msg: got %h want deadbeef", om8); else n_pass++;
        n_checks++; if (os8 !== 3'd5) $display("FAIL single_sel: got %0d want 5", os8); else n_pass++;
        // ptr should now be 6: channel 6 beats channel 0
        val8 = 8'b0100_0001; msg8[6*32 +: 32] = 32'h0000_0066; msg8[0 +: 32] = 32'h0000_0011;
        #1;
        n_checks++; if (rdy8 !== 8'b0100_0000) $display("FAIL ptr_after_5: got %b want 01000000", rdy8); else n_pass++;
        tick();
        n_checks++; if (om8 !== 32'h66 || os8 !== 3'd6) $display("FAIL ptr_after_5_out: got %h/%0d want 66/6", om8, os8); else n_pass++;
        val8 = '0;
        tick();
        n_checks++; if (ov8 !== 1'b0) $display("FAIL drain_val: got %b want 0", ov8); else n_pass++;
        n_checks++; if (om8 !== 32'h66 || os8 !== 3'd6) $display("FAIL drain_hold: got %h/%0d want 66/6", om8, os8); else n_pass++;
    endtask

    task automatic test_round_robin();
        reset8 = 1'b0;
        tick();
        reset8 = 1'b1;
        for (int i = 0; i < 8; i++) msg8[i*32 +: 32] = 32'(i + 47);
        val8 = '1; or8 = 1'b1; fe8 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_checks++; if (rdy8 !== 8'(1 << (k % 8))) $display("FAIL rr_grant[%0d]: got %b want %b", k, rdy8, 8'(1 << (k % 8))); else n_pass++;
            tick();
            n_checks++; if (ov8 !== 1'b1 || os8 !== 3'(k % 8) || om8 !== 32'(47 + k % 8))
                $display("FAIL rr_out[%0d]: got val=%b sel=%0d msg=%0d want 1/%0d/%0d", k, ov8, os8, om8, k % 8, 47 + k % 8);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        or8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (rdy8 !== 8'h00) $display("FAIL stall_rdy[%0d]: got %b want 0", c, rdy8); else n_pass++;
            tick();
            n_checks++; if (ov8 !== 1'b1 || os8 !== 3'd0 || om8 !== 32'd47)
                $display("FAIL stall_hold[%0d]: got val=%b sel=%0d msg=%0d want 1/0/47", c, ov8, os8, om8);
            else n_pass++;
        end
        or8 = 1'b1;
        #1;
        n_checks++; if (rdy8 !== 8'b0000_0010) $display("FAIL unstall_grant: got %b want 00000010", rdy8); else n_pass++;
        tick();
        n_checks++; if (ov8 !== 1'b1 || os8 !== 3'd1 || om8 !== 32'd48)
            $display("FAIL unstall_out: got val=%b sel=%0d msg=%0d want 1/1/48", ov8, os8, om8);
        else n_pass++;
        val8 = '0;
        tick();
        n_checks++; if (ov8 !== 1'b0 || om8 !== 32'd48) $display("FAIL bp_drain: got val=%b msg=%0d want 0/48", ov8, om8); else n_pass++;
    endtask

    task automatic test_fixed();
        reset4 = 1'b0; val4 = '0; msg4 = 16'hDCBA; fe4 = 1'b1; fs4 = 2'd2; or4 = 1'b1;
        tick();
        reset4 = 1'b1; val4 = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (rdy4 !== 4'b0100) $display("FAIL fixed_grant[%0d]: got %b want 0100", c, rdy4); else n_pass++;
            tick();
            n_checks++; if (ov4 !== 1'b1 || om4 !== 4'hC || os4 !== 2'd2)
                $display("FAIL fixed_out[%0d]: got val=%b msg=%h sel=%0d want 1/c/2", c, ov4, om4, os4);
            else n_pass++;
        end
        fe4 = 1'b0;
        #1;
        n_checks++; if (rdy4 !== 4'b0001) $display("FAIL fixed_ptr_kept: got %b want 0001", rdy4); else n_pass++;
        tick();
        n_checks++; if (om4 !== 4'hA || os4 !== 2'd0) $display("FAIL mode_switch_out: got %h/%0d want a/0", om4, os4); else n_pass++;
        fe4 = 1'b1; fs4 = 2'd2; val4 = 4'b1011;
        #1;
        n_checks++; if (rdy4 !== 4'b0000) $display("FAIL fixed_nowin: got %b want 0000", rdy4); else n_pass++;
        tick();
        n_checks++; if (ov4 !== 1'b0 || om4 !== 4'hA) $display("FAIL fixed_drain: got val=%b msg=%h want 0/a", ov4, om4); else n_pass++;
    endtask

    task automatic test_random(input int n, input int w);
        logic [63:0] q_msg [$];
        int          q_sel [$];
        int          waits [16];
        bit          pend  [16];
        logic [63:0] pm    [16];
        logic [63:0] mask;
        logic [63:0] em;
        int          es, gi;
        bit          acc, any;

        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r_which = n;
        for (int i = 0; i < 16; i++) begin
            pend[i] = 1'b0; pm[i] = '0; waits[i] = 0; r_msg[i] = '0;
        end
        r_val = '0; r_fe = 1'b0; r_fs = '0; r_ordy = 1'b1;
        r_reset = 1'b0;
        tick();
        for (int cyc = 0; cyc < 500; cyc++) begin
            r_reset = (cyc != 250);
            for (int i = 0; i < n; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pm[i]   = {$urandom, $urandom} & mask;
                end
                r_val[i] = pend[i];
                r_msg[i] = pm[i];
            end
            r_ordy = ($urandom_range(0, 3) != 0);
            r_fe   = ($urandom_range(0, 3) == 0);
            r_fs   = 4'($urandom_range(0, (n == 3) ? 3 : 15));
            #1;
            if (!r_reset) begin
                n_checks++; if (g_rdy !== 16'h0) $display("FAIL rnd%0d_reset_rdy[%0d]: got %h want 0", n, cyc, g_rdy); else n_pass++;
                q_msg.delete(); q_sel.delete();
                for (int i = 0; i < 16; i++) waits[i] = 0;
            end else begin
                acc = !g_oval || r_ordy;
                any = |r_val;
                if (r_fe) begin
                    n_checks++;
                    if (g_rdy !== ((acc && int'(r_fs) < n && pend[r_fs]) ? 16'(1 << r_fs) : 16'h0))
                        $display("FAIL rnd%0d_fixed_rdy[%0d]: got %h sel=%0d val=%h acc=%b", n, cyc, g_rdy, r_fs, r_val, acc);
                    else n_pass++;
                end else begin
                    n_checks++;
                    if ((acc && any) ? (!$onehot(g_rdy) || (g_rdy & ~r_val) != 0) : (g_rdy !== 16'h0))
                        $display("FAIL rnd%0d_rr_rdy[%0d]: got %h val=%h acc=%b", n, cyc, g_rdy, r_val, acc);
                    else n_pass++;
                end
                if (g_oval && r_ordy) begin
                    n_checks++;
                    if (q_msg.size() == 0) begin
                        $display("FAIL rnd%0d_extra_out[%0d]: got msg %h with empty scoreboard", n, cyc, g_omsg);
                    end else begin
                        em = q_msg.pop_front(); es = q_sel.pop_front();
                        if (g_omsg !== em || int'(g_osel) != es)
                            $display("FAIL rnd%0d_out[%0d]: got %h/%0d want %h/%0d", n, cyc, g_omsg, g_osel, em, es);
                        else n_pass++;
                    end
                end
                if (g_rdy != 16'h0) begin
                    gi = 0;
                    for (int i = 0; i < 16; i++) if (g_rdy[i]) gi = i;
                    q_msg.push_back(pm[gi]); q_sel.push_back(gi);
                    if (!r_fe) begin
                        for (int j = 0; j < n; j++) begin
                            if (j != gi && pend[j]) begin
                                waits[j]++;
                                n_checks++; if (waits[j] > n - 1) $display("FAIL rnd%0d_starve[%0d]: ch %0d waited %0d grants, max %0d", n, cyc, j, waits[j], n - 1); else n_pass++;
                            end
                        end
                    end
                    waits[gi] = 0;
                    pend[gi]  = 1'b0;
                end
            end
            tick();
        end
        r_val = '0;
    endtask

    initial begin
        reset8 = 1'b0; val8 = '0; msg8 = '0; fe8 = 1'b0; fs8 = '0; or8 = 1'b1;
        reset4 = 1'b0; val4 = '0; msg4 = '0; fe4 = 1'b0; fs4 = '0; or4 = 1'b1;
        r_reset = 1'b0; r_val = '0; r_fe = 1'b0; r_fs = '0; r_ordy = 1'b1; r_which = 3;
        for (int i = 0; i < 16; i++) r_msg[i] = '0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fixed();
        test_random(3, 1);
        test_random(16, 64);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
